// File: rtl/vreg_file.sv
`default_nettype none
// ============================================================================
// Module   : vreg_file
// Purpose  : Vector register file, NREGS x VLEN bits stored as LANE_W beats.
//            One lockstep two-operand (vs1/vs2) beat read stream with
//            valid/ready back-pressure and one byte-masked beat write port.
//            Define VRF_BYPASS_EN to merge a same-cycle write to the
//            streaming register/beat into the read data.
// Revision : 1.0 - initial release
// ============================================================================
module vreg_file #(
  parameter  int NREGS  = 32,
  parameter  int VLEN   = 128,
  parameter  int LANE_W = 32,
  localparam int BEATS  = VLEN / LANE_W,
  localparam int AW     = $clog2(NREGS),
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int NB     = LANE_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // read command
  input  logic              i_rd_req_valid,
  output logic              o_rd_req_ready,
  input  logic [AW-1:0]     i_rd_addr_a,
  input  logic [AW-1:0]     i_rd_addr_b,
  // read beat stream
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [LANE_W-1:0] o_rd_data_a,
  output logic [LANE_W-1:0] o_rd_data_b,
  output logic [BW-1:0]     o_rd_beat,
  output logic              o_rd_last,
  // beat write port
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [BW-1:0]     i_wr_beat,
  input  logic [NB-1:0]     i_wr_be,
  input  logic [LANE_W-1:0] i_wr_data
);

  localparam int            c_depth     = NREGS * BEATS;
  localparam int            c_iw        = (BEATS > 1) ? (AW + BW) : AW;
  localparam logic [BW-1:0] c_last_beat = BW'(BEATS - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BW-1:0]       r_beat;
  logic [BW-1:0]       w_beat_nxt;
  logic [AW-1:0]       r_addr_a;
  logic [AW-1:0]       r_addr_b;
  logic [AW-1:0]       w_addr_a_nxt;
  logic [AW-1:0]       w_addr_b_nxt;

  logic [LANE_W-1:0]   r_mem [c_depth];
  logic [c_iw-1:0]     w_wr_idx;
  logic [c_iw-1:0]     w_rd_idx_a;
  logic [c_iw-1:0]     w_rd_idx_b;
  logic [LANE_W-1:0]   w_word_a;
  logic [LANE_W-1:0]   w_word_b;
  logic                w_streaming;

  // Flat word index is {register, beat}; with a single beat the beat field vanishes
  generate
    if (BEATS > 1) begin : g_multi_beat
      assign w_wr_idx   = {i_wr_addr, i_wr_beat};
      assign w_rd_idx_a = {r_addr_a, r_beat};
      assign w_rd_idx_b = {r_addr_b, r_beat};
    end else begin : g_single_beat
      assign w_wr_idx   = i_wr_addr;
      assign w_rd_idx_a = r_addr_a;
      assign w_rd_idx_b = r_addr_b;
    end
  endgenerate

  assign w_streaming = (r_state == S_STREAM);

  // Storage: cleared on reset, byte-masked beat write otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < c_depth; w++) begin
        r_mem[w] <= '0;
      end
    end else if (i_wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (i_wr_be[i]) begin
          r_mem[w_wr_idx][8*i +: 8] <= i_wr_data[8*i +: 8];
        end
      end
    end
  end

  // Read FSM state, beat counter and latched operand addresses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_beat   <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_beat   <= w_beat_nxt;
      r_addr_a <= w_addr_a_nxt;
      r_addr_b <= w_addr_b_nxt;
    end
  end

  // Read FSM next state and handshake outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_nxt     = r_beat;
    w_addr_a_nxt   = r_addr_a;
    w_addr_b_nxt   = r_addr_b;
    o_rd_req_ready = 1'b0;
    o_rd_valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_rd_req_ready = 1'b1;
        if (i_rd_req_valid) begin
          w_addr_a_nxt = i_rd_addr_a;
          w_addr_b_nxt = i_rd_addr_b;
          w_beat_nxt   = '0;
          w_state_nxt  = S_STREAM;
        end
      end
      S_STREAM: begin
        o_rd_valid = 1'b1;
        if (i_rd_ready) begin
          if (r_beat == c_last_beat) begin
            w_beat_nxt  = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_beat_nxt = r_beat + BW'(1);
          end
        end
      end
      default: begin
        w_beat_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef VRF_BYPASS_EN
  logic w_byp_a;
  logic w_byp_b;
  assign w_byp_a = i_wr_en && (i_wr_addr == r_addr_a) && (i_wr_beat == r_beat);
  assign w_byp_b = i_wr_en && (i_wr_addr == r_addr_b) && (i_wr_beat == r_beat);
`endif

  // Read data: current storage word, with enabled bytes of a same-cycle write merged in when bypass is built
  always_comb begin
    w_word_a = r_mem[w_rd_idx_a];
    w_word_b = r_mem[w_rd_idx_b];
`ifdef VRF_BYPASS_EN
    for (int i = 0; i < NB; i++) begin
      if (w_byp_a && i_wr_be[i]) w_word_a[8*i +: 8] = i_wr_data[8*i +: 8];
      if (w_byp_b && i_wr_be[i]) w_word_b[8*i +: 8] = i_wr_data[8*i +: 8];
    end
`endif
    o_rd_data_a = w_streaming ? w_word_a : '0;
    o_rd_data_b = w_streaming ? w_word_b : '0;
    o_rd_beat   = w_streaming ? r_beat : '0;
    o_rd_last   = w_streaming && (r_beat == c_last_beat);
  end

endmodule
`default_nettype wire

// File: tb/tb_vreg_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_vreg_file
// Purpose  : Self-checking bench for vreg_file: randomized and directed
//            streams/writes against a queue/array reference model, with a
//            negedge monitor comparing every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vreg_file;

  localparam int NREGS  = 32;
  localparam int VLEN   = 128;
  localparam int LANE_W = 32;
  localparam int BEATS  = VLEN / LANE_W;
  localparam int AW     = $clog2(NREGS);
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int NB     = LANE_W / 8;

  logic              clk;
  logic              rst_n;
  logic              i_rd_req_valid;
  logic              o_rd_req_ready;
  logic [AW-1:0]     i_rd_addr_a;
  logic [AW-1:0]     i_rd_addr_b;
  logic              o_rd_valid;
  logic              i_rd_ready;
  logic [LANE_W-1:0] o_rd_data_a;
  logic [LANE_W-1:0] o_rd_data_b;
  logic [BW-1:0]     o_rd_beat;
  logic              o_rd_last;
  logic              i_wr_en;
  logic [AW-1:0]     i_wr_addr;
  logic [BW-1:0]     i_wr_beat;
  logic [NB-1:0]     i_wr_be;
  logic [LANE_W-1:0] i_wr_data;

  vreg_file #(.NREGS(NREGS), .VLEN(VLEN), .LANE_W(LANE_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_rd_req_valid (i_rd_req_valid),
    .o_rd_req_ready (o_rd_req_ready),
    .i_rd_addr_a    (i_rd_addr_a),
    .i_rd_addr_b    (i_rd_addr_b),
    .o_rd_valid     (o_rd_valid),
    .i_rd_ready     (i_rd_ready),
    .o_rd_data_a    (o_rd_data_a),
    .o_rd_data_b    (o_rd_data_b),
    .o_rd_beat      (o_rd_beat),
    .o_rd_last      (o_rd_last),
    .i_wr_en        (i_wr_en),
    .i_wr_addr      (i_wr_addr),
    .i_wr_beat      (i_wr_beat),
    .i_wr_be        (i_wr_be),
    .i_wr_data      (i_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register contents plus the queue of beats still owed
  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [BW-1:0] beat;
  } ent_t;

  logic [LANE_W-1:0] mem [NREGS][BEATS];
  ent_t              q[$];
  int                acc_cnt = 0;
  int                total   = 0;
  int                bad     = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endfunction

  // Expected beat data: stored word, plus same-cycle write merge when bypass is built
  function automatic logic [LANE_W-1:0] exp_data(input logic [AW-1:0] a, input logic [BW-1:0] bt);
    logic [LANE_W-1:0] d;
    d = mem[a][bt];
`ifdef VRF_BYPASS_EN
    if (i_wr_en && i_wr_addr == a && i_wr_beat == bt) begin
      for (int i = 0; i < NB; i++) begin
        if (i_wr_be[i]) d[8*i +: 8] = i_wr_data[8*i +: 8];
      end
    end
`endif
    return d;
  endfunction

  // Model update: accept/consume beats and commit writes at the clock edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++)
        for (int k = 0; k < BEATS; k++) mem[r][k] = '0;
      q.delete();
    end else begin
      if (q.size() != 0) begin
        if (i_rd_ready) void'(q.pop_front());
      end else if (i_rd_req_valid) begin
        for (int k = 0; k < BEATS; k++)
          q.push_back('{a: i_rd_addr_a, b: i_rd_addr_b, beat: BW'(k)});
        acc_cnt++;
      end
      if (i_wr_en) begin
        for (int i = 0; i < NB; i++)
          if (i_wr_be[i]) mem[i_wr_addr][i_wr_beat][8*i +: 8] = i_wr_data[8*i +: 8];
      end
    end
  end

  // Monitor: compare DUT outputs against the head of the expected queue each cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid", 64'(o_rd_valid), 64'd0);
      check("rst_req_ready", 64'(o_rd_req_ready), 64'd1);
      check("rst_last", 64'(o_rd_last), 64'd0);
      check("rst_data_a", 64'(o_rd_data_a), 64'd0);
      check("rst_data_b", 64'(o_rd_data_b), 64'd0);
      check("rst_beat", 64'(o_rd_beat), 64'd0);
    end else if (q.size() != 0) begin
      check("busy_req_ready", 64'(o_rd_req_ready), 64'd0);
      check("valid", 64'(o_rd_valid), 64'd1);
      check("beat", 64'(o_rd_beat), 64'(q[0].beat));
      check("last", 64'(o_rd_last), 64'(q[0].beat == BW'(BEATS - 1)));
      check("data_a", 64'(o_rd_data_a), 64'(exp_data(q[0].a, q[0].beat)));
      check("data_b", 64'(o_rd_data_b), 64'(exp_data(q[0].b, q[0].beat)));
    end else begin
      check("idle_req_ready", 64'(o_rd_req_ready), 64'd1);
      check("idle_valid", 64'(o_rd_valid), 64'd0);
      check("idle_last", 64'(o_rd_last), 64'd0);
      check("idle_data_a", 64'(o_rd_data_a), 64'd0);
      check("idle_data_b", 64'(o_rd_data_b), 64'd0);
      check("idle_beat", 64'(o_rd_beat), 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_beat(input int ad, input int bt, input logic [NB-1:0] be, input logic [LANE_W-1:0] d);
    i_wr_en   = 1'b1;
    i_wr_addr = AW'(ad);
    i_wr_beat = BW'(bt);
    i_wr_be   = be;
    i_wr_data = d;
    tick();
    i_wr_en   = 1'b0;
  endtask

  task automatic wait_accept(input int a, input int b);
    int start;
    int n;
    i_rd_req_valid = 1'b1;
    i_rd_addr_a    = AW'(a);
    i_rd_addr_b    = AW'(b);
    start = acc_cnt;
    n = 0;
    while (acc_cnt == start && n < 20) begin
      tick();
      n++;
    end
    if (acc_cnt == start) check("accept_timeout", 64'd0, 64'd1);
    i_rd_req_valid = 1'b0;
  endtask

  // One stream; optional stall (with command pulses) and write on stall_beat, optional single spot check of port a
  task automatic run_stream(input int a, input int b, input bit rnd,
                            input int stall_beat, input int stall_n, input bit do_wr,
                            input logic [NB-1:0] wbe, input logic [LANE_W-1:0] wd,
                            input int chk_beat, input logic [LANE_W-1:0] chk_val);
    int  n;
    int  stall_left;
    int  cur;
    bit  wr_done;
    bit  chk_done;
    wait_accept(a, b);
    stall_left = stall_n;
    wr_done    = 1'b0;
    chk_done   = 1'b0;
    n          = 0;
    while (q.size() != 0 && n < 200) begin
      cur            = int'(q[0].beat);
      i_rd_ready     = 1'b1;
      i_rd_req_valid = 1'b0;
      i_wr_en        = 1'b0;
      if (rnd) begin
        i_rd_ready     = 1'($urandom_range(0, 1));
        i_rd_req_valid = 1'($urandom_range(0, 1));
        i_rd_addr_a    = AW'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) begin
          i_wr_en   = 1'b1;
          i_wr_addr = ($urandom_range(0, 1) == 1) ? q[0].a : AW'($urandom_range(0, 7));
          i_wr_beat = ($urandom_range(0, 1) == 1) ? q[0].beat : BW'($urandom_range(0, BEATS - 1));
          i_wr_be   = NB'($urandom);
          i_wr_data = $urandom;
        end
      end else if (cur == stall_beat && stall_left > 0) begin
        i_rd_ready     = 1'b0;
        stall_left--;
        i_rd_req_valid = 1'(stall_left % 2);
        if (do_wr && !wr_done) begin
          i_wr_en   = 1'b1;
          i_wr_addr = AW'(a);
          i_wr_beat = BW'(cur);
          i_wr_be   = wbe;
          i_wr_data = wd;
          wr_done   = 1'b1;
        end
      end
      #1;
      if (!chk_done && cur == chk_beat) begin
        chk_done = 1'b1;
        check("spot_data_a", 64'(o_rd_data_a), 64'(chk_val));
      end
      tick();
      n++;
    end
    if (q.size() != 0) check("stream_timeout", 64'(q.size()), 64'd0);
    i_wr_en        = 1'b0;
    i_rd_req_valid = 1'b0;
    i_rd_ready     = 1'b1;
  endtask

  initial begin
    logic [LANE_W-1:0] byp_val;
    int                n;
`ifdef VRF_BYPASS_EN
    byp_val = 32'hDEAD2222;
`else
    byp_val = 32'h22222222;
`endif
    i_rd_req_valid = 1'b0;
    i_rd_addr_a    = '0;
    i_rd_addr_b    = '0;
    i_rd_ready     = 1'b1;
    i_wr_en        = 1'b0;
    i_wr_addr      = '0;
    i_wr_beat      = '0;
    i_wr_be        = '0;
    i_wr_data      = '0;
    rst_n          = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Zero contents after reset
    run_stream(3, 5, 1'b0, -1, 0, 1'b0, '0, '0, 2, 32'h0);

    // Full-beat writes then a same-register dual read
    for (int k = 0; k < BEATS; k++) write_beat(3, k, 4'hF, 32'h11111111 * (k + 1));
    run_stream(3, 3, 1'b0, -1, 0, 1'b0, '0, '0, 3, 32'h44444444);

    // Partial byte write merges with earlier contents
    write_beat(7, 2, 4'hF, 32'hAABBCCDD);
    write_beat(7, 2, 4'b0001, 32'h00000099);
    run_stream(7, 3, 1'b0, -1, 0, 1'b0, '0, '0, 2, 32'hAABBCC99);

    // Back-pressure hold on beat 1 with ignored command pulses
    run_stream(3, 7, 1'b0, 1, 3, 1'b0, '0, '0, 1, 32'h22222222);

    // Write to the streaming beat while it is presented (then held one cycle)
    run_stream(3, 3, 1'b0, 1, 2, 1'b1, 4'b1100, 32'hDEADBEEF, 1, byp_val);

    // Randomized writes and streams over a small register window
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 3))
        write_beat($urandom_range(0, 7), $urandom_range(0, BEATS - 1), NB'($urandom), $urandom);
      run_stream($urandom_range(0, 7), $urandom_range(0, 7), 1'b1, -1, 0, 1'b0, '0, '0, -1, '0);
    end

    // Reset in the middle of beat 2 drops the stream
    wait_accept(3, 5);
    n = 0;
    while (q.size() != 0 && q[0].beat != BW'(2) && n < 20) begin
      tick();
      n++;
    end
    if (q.size() == 0) check("reach_beat2", 64'd0, 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(o_rd_valid), 64'd0);
    check("async_rst_last", 64'(o_rd_last), 64'd0);
    check("async_rst_req_ready", 64'(o_rd_req_ready), 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_stream(3, 5, 1'b0, -1, 0, 1'b0, '0, '0, 1, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
